// File: rtl/lockstep_pkg.sv
// Shared types and defaults for the dual-core lockstep checker.
// Both cores pack their bus outputs through cmp_vec_t so the compare lines up bit for bit.
package lockstep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    HALT    = 3'd2,
    RECOVER = 3'd3,
    FATAL   = 3'd4
  } ls_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        instr_req;
    logic        data_req;
    logic        data_we;
    logic        data_atomic;
  } cmp_vec_t;

  localparam int CMP_W_DEF           = $bits(cmp_vec_t);
  localparam int HALT_CYCLES_DEF     = 4;
  localparam int RECOVER_TIMEOUT_DEF = 16;
  localparam int MAX_RETRY_DEF       = 3;
  localparam int CLEAN_WINDOW_DEF    = 32;
  localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/ft_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ft_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         count_o <= '0;
    else if (clr_i)                    count_o <= '0;
    else if (inc_i && count_o != '1)   count_o <= count_o + 1'b1;
  end

endmodule

// File: rtl/lockstep_checker.sv
// Compares core_0/core_1 bus outputs each valid cycle; on divergence it halts,
// drives a timed recovery handshake, and escalates to a sticky FATAL.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int CMP_W           = CMP_W_DEF,
  parameter int HALT_CYCLES     = HALT_CYCLES_DEF,
  parameter int RECOVER_TIMEOUT = RECOVER_TIMEOUT_DEF,
  parameter int MAX_RETRY       = MAX_RETRY_DEF,
  parameter int CLEAN_WINDOW    = CLEAN_WINDOW_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             cmp_valid_i,
  input  logic [CMP_W-1:0] core0_sig_i,
  input  logic [CMP_W-1:0] core1_sig_i,
  input  logic             recover_done_i,
  output logic             error_o,
  output logic             halt_o,
  output logic             recover_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] error_count_o,
  output logic [CMP_W-1:0] syndrome_o,
  output logic [2:0]       state_o
);

  localparam int TMR_MAX = (HALT_CYCLES > RECOVER_TIMEOUT) ? HALT_CYCLES : RECOVER_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CLN_W   = $clog2(CLEAN_WINDOW + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  ls_state_e        state_q, state_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] tmr;
  logic [CLN_W-1:0] clean;
  logic             mismatch, err_d, clean_inc, clean_wrap;

  assign mismatch = cmp_valid_i && (core0_sig_i != core1_sig_i);

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    err_d      = 1'b0;
    clean_inc  = 1'b0;
    clean_wrap = 1'b0;
    case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN: begin
        // Dropping enable outranks a same-cycle mismatch.
        if (!enable_i) state_d = IDLE;
        else if (mismatch) begin
          err_d   = 1'b1;
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RTY_W'(MAX_RETRY)) ? FATAL : HALT;
        end else if (cmp_valid_i) begin
          clean_inc = 1'b1;
          if (clean == CLN_W'(CLEAN_WINDOW - 1)) begin
            clean_wrap = 1'b1;
            retry_d    = '0;
          end
        end
      end
      HALT:    if (tmr == TMR_W'(HALT_CYCLES - 1)) state_d = RECOVER;
      RECOVER: begin
        if (recover_done_i) state_d = RUN;
        else if (tmr == TMR_W'(RECOVER_TIMEOUT - 1)) state_d = FATAL;
      end
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end

  ft_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(err_d), .clr_i(1'b0), .count_o(error_count_o)
  );

  ft_sat_counter #(.W(CLN_W)) u_clean_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(clean_inc), .clr_i(err_d | clean_wrap), .count_o(clean)
  );

  // Phase timer restarts on every state change, so it reads cycles-in-state.
  ft_sat_counter #(.W(TMR_W)) u_phase_tmr (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1), .clr_i(state_d != state_q), .count_o(tmr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      error_o    <= 1'b0;
      halt_o     <= 1'b0;
      recover_o  <= 1'b0;
      fatal_o    <= 1'b0;
      syndrome_o <= '0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      error_o   <= err_d;
      halt_o    <= (state_d == HALT) || (state_d == RECOVER) || (state_d == FATAL);
      recover_o <= (state_d == RECOVER);
      fatal_o   <= (state_d == FATAL);
      if (err_d) syndrome_o <= core0_sig_i ^ core1_sig_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Randomized and directed bench for lockstep_checker against a cycle-level behavioural model.
module tb_lockstep_checker;

  localparam int CMP_W = 72, HALT_CYCLES = 4, RECOVER_TIMEOUT = 16;
  localparam int MAX_RETRY = 3, CLEAN_WINDOW = 32, CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_RECOVER = 3, S_FATAL = 4;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, valid = 1'b0, done = 1'b0;
  logic [CMP_W-1:0] c0 = '0, c1 = '0;
  logic error, halt, recover, fatal;
  logic [CNT_W-1:0] cnt;
  logic [CMP_W-1:0] syn;
  logic [2:0] st;

  int errors = 0, checks = 0;

  // Model: mode, cycles already spent in it, retry/clean bookkeeping, visible results.
  int m_st = 0, m_age = 0, m_retry = 0, m_clean = 0, m_cnt = 0;
  logic [CMP_W-1:0] m_syn = '0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  lockstep_checker #(
    .CMP_W(CMP_W), .HALT_CYCLES(HALT_CYCLES), .RECOVER_TIMEOUT(RECOVER_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .CLEAN_WINDOW(CLEAN_WINDOW), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .cmp_valid_i(valid),
    .core0_sig_i(c0), .core1_sig_i(c1), .recover_done_i(done),
    .error_o(error), .halt_o(halt), .recover_o(recover), .fatal_o(fatal),
    .error_count_o(cnt), .syndrome_o(syn), .state_o(st)
  );

  task automatic chk(input string name, input logic [CMP_W-1:0] act, input logic [CMP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_st = S_IDLE; m_age = 0; m_retry = 0; m_clean = 0; m_cnt = 0; m_syn = '0; m_err = 1'b0;
  endtask

  task model_step();
    int nxt;
    if (rst) begin model_reset(); return; end
    nxt   = m_st;
    m_err = 1'b0;
    case (m_st)
      S_IDLE: if (en) nxt = S_RUN;
      S_RUN: begin
        if (!en) nxt = S_IDLE;
        else if (valid && c0 != c1) begin
          m_err   = 1'b1;
          m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
          m_syn   = c0 ^ c1;
          m_retry = m_retry + 1;
          m_clean = 0;
          nxt     = (m_retry == MAX_RETRY) ? S_FATAL : S_HALT;
        end else if (valid) begin
          m_clean = m_clean + 1;
          if (m_clean == CLEAN_WINDOW) begin m_clean = 0; m_retry = 0; end
        end
      end
      S_HALT:    if (m_age == HALT_CYCLES - 1) nxt = S_RECOVER;
      S_RECOVER: if (done) nxt = S_RUN; else if (m_age == RECOVER_TIMEOUT - 1) nxt = S_FATAL;
      default:   nxt = m_st;
    endcase
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    chk("error_o",       CMP_W'(error),   CMP_W'(m_err));
    chk("halt_o",        CMP_W'(halt),    CMP_W'(m_st >= S_HALT));
    chk("recover_o",     CMP_W'(recover), CMP_W'(m_st == S_RECOVER));
    chk("fatal_o",       CMP_W'(fatal),   CMP_W'(m_st == S_FATAL));
    chk("error_count_o", CMP_W'(cnt),     CMP_W'(m_cnt));
    chk("syndrome_o",    syn,             m_syn);
    chk("state_o",       CMP_W'(st),      CMP_W'(m_st));
  end

  function automatic logic [CMP_W-1:0] rvec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CMP_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit mism);
    logic [CMP_W-1:0] flip;
    flip  = CMP_W'(1) << $urandom_range(0, CMP_W - 1);
    valid = v;
    c0    = rvec();
    c1    = mism ? (c0 ^ flip) : c0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    en = 1'b0; valid = 1'b0; done = 1'b0;
    #1;
    chk("async_reset_state", CMP_W'(st),   CMP_W'(0));
    chk("async_reset_halt",  CMP_W'(halt), CMP_W'(0));
    chk("async_reset_cnt",   CMP_W'(cnt),  CMP_W'(0));
    tick();
    rst = 1'b0;
  endtask

  task automatic clean(input int n);
    repeat (n) begin drive(1'b1, 1'b0); tick(); end
  endtask

  task automatic err_recover();
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0);
    repeat (HALT_CYCLES) tick();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    chk("reset_fatal", CMP_W'(fatal), CMP_W'(0));

    // Long clean run
    en = 1'b1;
    clean(200);
    chk("clean_state", CMP_W'(st),  CMP_W'(S_RUN));
    chk("clean_cnt",   CMP_W'(cnt), CMP_W'(0));

    // Single bit flip on core1 bit 5
    valid = 1'b1; c0 = rvec(); c1 = c0 ^ CMP_W'(32'h20);
    tick();
    chk("flip_error",    CMP_W'(error), CMP_W'(1));
    chk("flip_halt",     CMP_W'(halt),  CMP_W'(1));
    chk("flip_syndrome", syn,           CMP_W'(32'h20));
    chk("flip_cnt",      CMP_W'(cnt),   CMP_W'(1));
    drive(1'b1, 1'b0);
    tick();
    chk("flip_error_1cyc", CMP_W'(error), CMP_W'(0));
    tick(); tick();
    chk("flip_halt_end_no_rec", CMP_W'(recover), CMP_W'(0));
    tick();
    chk("flip_recover_rise", CMP_W'(recover), CMP_W'(1));
    repeat (3) tick();
    done = 1'b1; tick(); done = 1'b0;
    chk("flip_back_run", CMP_W'(st),   CMP_W'(S_RUN));
    chk("flip_halt_low", CMP_W'(halt), CMP_W'(0));

    // Recovery timeout
    do_reset();
    en = 1'b1; tick();
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0);
    repeat (HALT_CYCLES) tick();
    repeat (RECOVER_TIMEOUT - 1) tick();
    chk("timeout_last_recover", CMP_W'(st), CMP_W'(S_RECOVER));
    tick();
    chk("timeout_fatal",   CMP_W'(fatal),   CMP_W'(1));
    chk("timeout_rec_low", CMP_W'(recover), CMP_W'(0));
    repeat (5) begin en = 1'($urandom); done = 1'($urandom); tick(); end
    chk("fatal_sticky", CMP_W'(st), CMP_W'(S_FATAL));
    do_reset();
    chk("after_fatal_cnt", CMP_W'(cnt), CMP_W'(0));

    // Three close mismatches escalate
    en = 1'b1; tick();
    err_recover(); clean(10);
    err_recover(); clean(10);
    drive(1'b1, 1'b1); tick();
    chk("retry_fatal", CMP_W'(st),  CMP_W'(S_FATAL));
    chk("retry_cnt",   CMP_W'(cnt), CMP_W'(3));

    // Widely spaced mismatches recover, then the counter saturates
    do_reset();
    en = 1'b1; tick();
    repeat (3) begin clean(40); err_recover(); end
    chk("spaced_run",   CMP_W'(st),  CMP_W'(S_RUN));
    chk("spaced_cnt",   CMP_W'(cnt), CMP_W'(3));
    clean(40); err_recover();
    chk("sat_cnt",   CMP_W'(cnt), CMP_W'(3));
    chk("sat_state", CMP_W'(st),  CMP_W'(S_RUN));

    // Ignored mismatches
    do_reset();
    en = 1'b1; tick(); clean(5);
    repeat (3) begin drive(1'b0, 1'b1); tick(); end
    chk("invalid_no_err", CMP_W'(cnt), CMP_W'(0));
    drive(1'b1, 1'b1); tick();
    repeat (HALT_CYCLES) begin drive(1'b1, 1'b1); tick(); end
    chk("halt_mism_cnt", CMP_W'(cnt), CMP_W'(1));
    drive(1'b1, 1'b0); done = 1'b1; tick(); done = 1'b0;
    en = 1'b0; drive(1'b1, 1'b1); tick();
    chk("en_fall_state", CMP_W'(st),    CMP_W'(S_IDLE));
    chk("en_fall_error", CMP_W'(error), CMP_W'(0));
    chk("en_fall_cnt",   CMP_W'(cnt),   CMP_W'(1));

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      en   = ($urandom_range(0, 19) != 0);
      done = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Synthesizable responder to register-file fault injection in the dual-core lockstep SoC: compares the bus-visible outputs of core_0 and core_1 every valid cycle.
- On divergence it pulses an error, stalls both cores, runs a timed recovery handshake, and escalates to a sticky fatal state on repeated or unrecoverable faults.
- Sits between the two cores and the shared instruction/data memory ports. Its error_o is the signal the bench counts as a detected error.

Parameters:
- CMP_W, 72, width of the per-core compare vector (addr, wdata, be, req and we flags, packed identically for both cores).
- HALT_CYCLES, 4, cycles spent in HALT draining in-flight bus transactions.
- RECOVER_TIMEOUT, 16, maximum cycles in RECOVER waiting for recover_done_i.
- MAX_RETRY, 3, consecutive errors allowed before FATAL.
- CLEAN_WINDOW, 32, consecutive clean valid compares in RUN that clear the retry count.
- CNT_W, 16, width of the error counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  checking enable (tied to fetch_enable).
- cmp_valid_i  in  1  compare vectors are meaningful this cycle.
- core0_sig_i  in  CMP_W  core_0 output vector.
- core1_sig_i  in  CMP_W  core_1 output vector.
- recover_done_i  in  1  cores report state restore complete.
- error_o  out  1  one-cycle pulse per detected mismatch.
- halt_o  out  1  stall both cores.
- recover_o  out  1  request core state restore.
- fatal_o  out  1  sticky unrecoverable fault.
- error_count_o  out  CNT_W  saturating total error count.
- syndrome_o  out  CMP_W  XOR of the vectors at the last detected mismatch.
- state_o  out  3  FSM state encoding, for debug.

Behaviour:
- Reset, async on rst_i high: state=IDLE. All outputs 0. Retry and clean counters 0. Reset mid-operation aborts any HALT/RECOVER immediately, and FATAL is also cleared.
- Mismatch term: cmp_valid_i && (core0_sig_i != core1_sig_i). It is evaluated only in RUN and ignored in every other state.
- IDLE -> RUN on the clock edge where enable_i=1.
- RUN, enable_i=0: next state IDLE. Enable has priority over a same-cycle mismatch, so that mismatch is not counted.
- RUN, mismatch sampled at edge E:
  - error_o=1 in the cycle after E, for exactly one cycle.
  - error_count_o increments, saturating at all-ones.
  - syndrome_o latches core0^core1.
  - retry count increments and the clean counter clears.
  - If the incremented retry count == MAX_RETRY, next state is FATAL; otherwise next state is HALT.
- Detection latency is 1 cycle: halt_o and error_o rise together.
- RUN, clean valid compare: clean counter increments. When it reaches CLEAN_WINDOW, the retry count clears and the clean counter restarts. Invalid cycles neither increment nor clear it.
- HALT: halt_o=1 for exactly HALT_CYCLES cycles, then RECOVER. enable_i is ignored.
- RECOVER:
  - halt_o=1 and recover_o=1.
  - recover_done_i=1 -> RUN on the next edge; halt_o and recover_o drop in that cycle.
  - If recover_done_i is not seen within RECOVER_TIMEOUT cycles -> FATAL.
  - recover_done_i outside RECOVER is ignored.
- FATAL: halt_o=1, fatal_o=1, recover_o=0. Stays here until rst_i.
- All outputs are registered. halt_o=1 in HALT, RECOVER and FATAL.
- Phase counters are sized $clog2 of their max+1 and reset on every state entry.

Decomposition:
- Package lockstep_pkg holds:
  - the state enum (IDLE=0, RUN=1, HALT=2, RECOVER=3, FATAL=4), 3 bits;
  - default parameter constants;
  - a packed struct describing the compare-vector field layout, so the SoC packs both cores identically.
- Sub-module ft_sat_counter (parameter W; inc_i, clr_i, count_o; saturating). It is instantiated for the error count, the clean counter and the phase timer.

Test Plan:
- Equal vectors for 200 valid cycles after enable -> state RUN; error_o, halt_o and fatal_o stay 0; error_count_o=0.
- Single bit flip at cycle 50 (core1 bit 5 inverted) -> error_o pulses 1 cycle at 51; syndrome_o=0x20; halt_o high for 4 cycles; recover_o rises at 55; recover_done_i at 58 -> RUN at 59; count=1.
- RECOVER with recover_done_i held 0 -> fatal_o=1 after 16 RECOVER cycles. A later rst_i pulse returns to IDLE with count=0.
- Three mismatches, each separated by 10 clean compares -> the third goes straight to FATAL; count=3.
- Three mismatches, each separated by 40 clean compares -> never FATAL; count=3; every error is followed by a recovery.
- Mismatch with cmp_valid_i=0, or during HALT, or in the same cycle as enable_i falling -> no error_o and no count change. Count preset near saturation with CNT_W=2: a 4th error leaves it at 3.
